demux_1x4: RTL and testbench

Registered 1-to-4 stream demultiplexer: the distribution-side counterpart of the 4-to-1 multiplexer. One valid/ready input stream is steered, word by word, to one of four output lanes chosen by `select`. Each lane owns a 2-entry FIFO so that lanes drain independently. A stalled lane blocks only words addressed to it. Sits between a single producer and four independent consumers.

---
 rtl/demux_pkg.sv | 8 +
 rtl/demux_lane_fifo.sv | 44 ++++
 rtl/demux_1x4.sv | 45 ++++
 tb/tb_demux_1x4.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the 1-to-4 stream demultiplexer
package demux_pkg;
    localparam int LANES      = 4;
    localparam int LANE_DEPTH = 2;
    localparam int SEL_W      = $clog2(LANES);
    localparam int DEF_WIDTH  = 32;
    typedef logic [1:0] cnt_t;
endpackage

// File: rtl/demux_lane_fifo.sv
// demux_lane_fifo: 2-entry per-lane FIFO with registered head and occupancy
module demux_lane_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output cnt_t             count
);
    logic [WIDTH-1:0] mem [LANE_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             pop;

    // a full lane never takes a word, even if it pops in the same cycle
    assign do_push    = push && (count != cnt_t'(LANE_DEPTH));
    assign pop        = head_valid && pop_ready;
    assign head_valid = count != '0;
    assign head       = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + cnt_t'(do_push) - cnt_t'(pop);
        end
    end
endmodule

// File: rtl/demux_1x4.sv
// demux_1x4: routes one valid/ready stream to four independently drained lanes
module demux_1x4
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] select,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [LANES-1:0] out_valid,
    input  logic [LANES-1:0] out_ready,
    output logic             busy
);
    cnt_t             cnt   [LANES];
    logic [WIDTH-1:0] heads [LANES];
    logic [LANES-1:0] push;

    assign in_ready = cnt[select] < cnt_t'(LANE_DEPTH);
    assign push     = {LANES{in_valid && in_ready}} & (LANES'(1) << select);
    assign busy     = |out_valid;
    assign out0     = heads[0];
    assign out1     = heads[1];
    assign out2     = heads[2];
    assign out3     = heads[3];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        demux_lane_fifo #(.WIDTH(WIDTH)) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .push       (push[g]),
            .push_data  (in_data),
            .pop_ready  (out_ready[g]),
            .head       (heads[g]),
            .head_valid (out_valid[g]),
            .count      (cnt[g])
        );
    end
endmodule

// File: tb/tb_demux_1x4.sv
// tb_demux_1x4: directed vector table, corner sequences and scoreboard soak for demux_1x4
module tb_demux_1x4;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  select;
    logic [31:0] out0, out1, out2, out3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        busy;
    logic [31:0] outs [4];
    int          n_vec = 0;
    int          n_bad = 0;

    typedef struct {
        logic            iv;
        logic [1:0]      sel;
        logic [31:0]     d;
        logic [3:0]      ordy;
        logic            ir;
        logic [3:0]      ov;
        logic [3:0][31:0] o;
    } vec_t;

    vec_t        v [15];
    logic [31:0] q [4][$];

    demux_1x4 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .select    (select),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [1:0] sel, input logic [31:0] d,
                                input logic [3:0] ordy, input logic ir, input logic [3:0] ov,
                                input logic [3:0][31:0] o);
        vec_t r;
        r.iv = iv; r.sel = sel; r.d = d; r.ordy = ordy; r.ir = ir; r.ov = ov; r.o = o;
        return r;
    endfunction

    task automatic chk_empty(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_out%0d", tag, i), outs[i], 32'h0);
    endtask

    initial begin
        // outputs listed {out3,out2,out1,out0}; in_ready checked before the edge, the rest after
        v[0]  = mk(1, 2, 32'hA5A5_0001, 4'b0000, 1, 4'b0100, {32'h0, 32'hA5A5_0001, 32'h0, 32'h0});
        v[1]  = mk(0, 2, 32'h0,         4'b0100, 1, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0});
        v[2]  = mk(1, 1, 32'h11,        4'b0000, 1, 4'b0010, {32'h0, 32'h0, 32'h11, 32'h0});
        v[3]  = mk(1, 1, 32'h22,        4'b0000, 1, 4'b0010, {32'h0, 32'h0, 32'h11, 32'h0});
        v[4]  = mk(1, 1, 32'h33,        4'b0000, 0, 4'b0010, {32'h0, 32'h0, 32'h11, 32'h0});
        v[5]  = mk(1, 3, 32'h44,        4'b0000, 1, 4'b1010, {32'h44, 32'h0, 32'h11, 32'h0});
        v[6]  = mk(0, 1, 32'h0,         4'b0010, 0, 4'b1010, {32'h44, 32'h0, 32'h22, 32'h0});
        v[7]  = mk(1, 1, 32'h55,        4'b0010, 1, 4'b1010, {32'h44, 32'h0, 32'h55, 32'h0});
        v[8]  = mk(0, 0, 32'h0,         4'b1010, 1, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0});
        v[9]  = mk(1, 0, 32'hA,         4'b0000, 1, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hA});
        v[10] = mk(1, 0, 32'hB,         4'b0000, 1, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hA});
        v[11] = mk(1, 0, 32'hC,         4'b0001, 0, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hB});
        v[12] = mk(1, 0, 32'hC,         4'b0000, 1, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hB});
        v[13] = mk(0, 0, 32'h0,         4'b0001, 0, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hC});
        v[14] = mk(0, 0, 32'h0,         4'b0001, 1, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0});

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; select = '0; out_ready = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 1'($urandom); select = 2'($urandom); in_data = $urandom; out_ready = 4'($urandom);
            #1 chk_empty("reset");
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = '0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            in_valid = v[i].iv; select = v[i].sel; in_data = v[i].d; out_ready = v[i].ordy;
            #1 chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(v[i].ir));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(v[i].ov));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(|v[i].ov));
            for (int l = 0; l < 4; l++)
                chk($sformatf("vec%0d_out%0d", i, l), outs[l], v[i].o[l]);
        end

        @(negedge clk);
        select = 2'd3; out_ready = 4'b1000; in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            in_data = 32'(k);
            #1 chk($sformatf("stream%0d_in_ready", k), 32'(in_ready), 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d_out_valid", k), 32'(out_valid), 32'h8);
            chk($sformatf("stream%0d_out3", k), out3, 32'(k));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk("stream_drain_out_valid", 32'(out_valid), 32'h0);

        out_ready = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; select = 2'(k); in_data = 32'hD000 + 32'(k);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("burst_out_valid", 32'(out_valid), 32'h7);
        #2 rst_n = 1'b0;
        #1 chk_empty("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 10000; c++) begin
            logic acc;
            @(negedge clk);
            in_valid = 1'($urandom); select = 2'($urandom); in_data = $urandom; out_ready = 4'($urandom);
            #1;
            acc = in_valid && (q[select].size() < 2);
            chk("soak_in_ready", 32'(in_ready), 32'(q[select].size() < 2));
            for (int l = 0; l < 4; l++) begin
                chk($sformatf("soak_out_valid%0d", l), 32'(out_valid[l]), 32'(q[l].size() != 0));
                chk($sformatf("soak_out%0d", l), outs[l], q[l].size() != 0 ? q[l][0] : 32'h0);
                if (out_ready[l] && q[l].size() != 0)
                    void'(q[l].pop_front());
            end
            if (acc)
                q[select].push_back(in_data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
